// File: rtl/vram_scanout_pkg.sv
// Shared constants and types for the text-mode scanout: default VGA 640x480
// timing, cell word field offsets and glyph geometry.
package vram_scanout_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = 12;

    localparam int CHAR_LSB = 0;
    localparam int FG_LSB   = 8;
    localparam int BG_LSB   = 12;

    localparam int GLYPH_H = 16;
    localparam int GLYPH_W = 8;

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic sof;
    } vid_ctl_t;

    function automatic logic in_window(input logic [CNT_W-1:0] cnt, input int lo, input int len);
        return (int'(cnt) >= lo) && (int'(cnt) < lo + len);
    endfunction

endpackage

// File: rtl/vram_scanout_if.sv
// Read-only bus to VRAM port B and the font ROM, driven by the scanout engine.
interface vram_scanout_if;
    import vram_scanout_pkg::*;

    // No handshake: both memories return data exactly one cycle after the
    // address; vram_ceb qualifies the VRAM address, the font ROM reads every cycle.
    logic              vram_ceb;
    logic [ADDR_W-1:0] vram_adb;
    logic [15:0]       vram_doutb;
    logic [ADDR_W-1:0] font_addr;
    logic [7:0]        font_data;

    modport master (
        output vram_ceb, vram_adb, font_addr,
        input  vram_doutb, font_data
    );

    modport slave (
        input  vram_ceb, vram_adb, font_addr,
        output vram_doutb, font_data
    );

endinterface

// File: rtl/vram_scanout_timing.sv
// Raster counters with raw (unpipelined) active/sync flags and wrap strobes.
module vram_scanout_timing
    import vram_scanout_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic                       clk,
    input  logic                       resetn,
    output logic [CNT_W-1:0]           hcnt,
    output logic [$clog2(GLYPH_H)-1:0] glyph_row,
    output logic                       active,
    output logic                       hsync_on,
    output logic                       vsync_on,
    output logic                       line_end,
    output logic                       frame_end,
    output logic                       first
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] vcnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (line_end) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign line_end  = (hcnt == H_LAST);
    assign frame_end = line_end && (vcnt == V_LAST);
    assign first     = (hcnt == '0) && (vcnt == '0);
    assign active    = (hcnt < CNT_W'(H_ACTIVE)) && (vcnt < CNT_W'(V_ACTIVE));
    assign hsync_on  = in_window(hcnt, H_ACTIVE + H_FP, H_SYNC);
    assign vsync_on  = in_window(vcnt, V_ACTIVE + V_FP, V_SYNC);
    assign glyph_row = vcnt[$clog2(GLYPH_H)-1:0];

endmodule

// File: rtl/vram_scanout.sv
// Text-mode scanout: cell fetch, font lookup, underline cursor and a fixed
// 3-cycle pipeline from raster counters to colour index and syncs.
module vram_scanout
    import vram_scanout_pkg::*;
#(
    parameter int                H_ACTIVE     = H_ACTIVE_DEF,
    parameter int                H_FP         = H_FP_DEF,
    parameter int                H_SYNC       = H_SYNC_DEF,
    parameter int                H_BP         = H_BP_DEF,
    parameter int                V_ACTIVE     = V_ACTIVE_DEF,
    parameter int                V_FP         = V_FP_DEF,
    parameter int                V_SYNC       = V_SYNC_DEF,
    parameter int                V_BP         = V_BP_DEF,
    parameter int                COLS         = 80,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 12'h000,
    parameter int                BLINK_FRAMES = 32,
    parameter logic              SYNC_POL     = 1'b0
) (
    input  logic              clk,
    input  logic              resetn,
    vram_scanout_if.master    mem,
    input  logic              cursor_en,
    input  logic [ADDR_W-1:0] cursor_addr,
    output logic [3:0]        pix_idx,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);
    localparam int X_BITS   = $clog2(GLYPH_W);
    localparam int ROW_BITS = $clog2(GLYPH_H);
    localparam int BLINK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0]    hcnt;
    logic [ROW_BITS-1:0] glyph_row;
    logic                t_active, t_hsync, t_vsync, t_line_end, t_frame_end, t_first;

    vram_scanout_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk       (clk),
        .resetn    (resetn),
        .hcnt      (hcnt),
        .glyph_row (glyph_row),
        .active    (t_active),
        .hsync_on  (t_hsync),
        .vsync_on  (t_vsync),
        .line_end  (t_line_end),
        .frame_end (t_frame_end),
        .first     (t_first)
    );

    // Row base advances by one text row after the last glyph line, avoiding a multiplier.
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] cell_addr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            row_base <= BASE_ADDR;
        end else if (t_frame_end) begin
            row_base <= BASE_ADDR;
        end else if (t_line_end && (glyph_row == '1)) begin
            row_base <= row_base + ADDR_W'(COLS);
        end
    end

    assign cell_addr    = row_base + ADDR_W'(hcnt[CNT_W-1:X_BITS]);
    assign mem.vram_adb = cell_addr;
    assign mem.vram_ceb = t_active & resetn;

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (t_frame_end) begin
            if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    vid_ctl_t            ctl0, s1_ctl, s2_ctl;
    logic [X_BITS-1:0]   s1_x, s2_x;
    logic [ROW_BITS-1:0] s1_row, s2_row;
    logic [3:0]          s2_fg, s2_bg;
    logic                cell_match, s2_match;

    assign ctl0 = '{active: t_active, hsync: t_hsync, vsync: t_vsync, sof: t_first};

    // Cursor match is captured once per cell so a mid-cell change lands on the next cell.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_ctl     <= '0;
            s1_x       <= '0;
            s1_row     <= '0;
            cell_match <= 1'b0;
            s2_ctl     <= '0;
            s2_x       <= '0;
            s2_row     <= '0;
            s2_fg      <= '0;
            s2_bg      <= '0;
            s2_match   <= 1'b0;
        end else begin
            s1_ctl <= ctl0;
            s1_x   <= hcnt[X_BITS-1:0];
            s1_row <= glyph_row;
            if (hcnt[X_BITS-1:0] == '0) begin
                cell_match <= cursor_en && (cell_addr == cursor_addr);
            end
            s2_ctl   <= s1_ctl;
            s2_x     <= s1_x;
            s2_row   <= s1_row;
            s2_fg    <= mem.vram_doutb[FG_LSB +: 4];
            s2_bg    <= mem.vram_doutb[BG_LSB +: 4];
            s2_match <= cell_match;
        end
    end

    assign mem.font_addr = {mem.vram_doutb[CHAR_LSB +: 8], s1_row};

    logic glyph_bit, cursor_row, pix_bit;

    assign glyph_bit  = mem.font_data[X_BITS'(GLYPH_W - 1) - s2_x];
    assign cursor_row = (s2_row >= ROW_BITS'(GLYPH_H - 2));
    assign pix_bit    = glyph_bit | (s2_match & blink_on & cursor_row);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pix_idx     <= 4'h0;
            de          <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            pix_idx     <= s2_ctl.active ? (pix_bit ? s2_fg : s2_bg) : 4'h0;
            de          <= s2_ctl.active;
            hsync       <= s2_ctl.hsync ? SYNC_POL : ~SYNC_POL;
            vsync       <= s2_ctl.vsync ? SYNC_POL : ~SYNC_POL;
            frame_start <= s2_ctl.sof;
        end
    end

endmodule
